// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Optional feature macro: SERIAL_PATTERN_TX_PARITY_EN (appends an even-parity bit to each frame).
package serial_pattern_tx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } tx_state_t;

    // Number of dout_valid cycles per frame for a given data width.
    function automatic int unsigned frame_len(input int unsigned width);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/serial_pattern_tx_hold.sv
// One-word holding register with full flag; lets the next word wait while a frame is on the wire.
module serial_pattern_tx_hold
    import serial_pattern_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             load_ready
);

    logic             full;
    logic [WIDTH-1:0] data;

    // Full flag: set on write, cleared when the word moves into the shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (wr_en) begin
            full <= 1'b1;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

    // Data storage; contents are meaningless while the flag is clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data <= wr_data;
        end
    end

    assign rd_data    = data;
    assign load_ready = !full;

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: parallel words in over valid/ready, MSB-first bit stream out.
// Optional feature macro: SERIAL_PATTERN_TX_PARITY_EN (adds a PARITY cycle carrying even parity).
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned    CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    tx_state_t        state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             accept;
    logic             direct;
    logic             hold_wr, hold_rd;
    logic [WIDTH-1:0] hold_data;
    logic             last_bit;
    logic             do_load;
    logic [WIDTH-1:0] new_word;
    logic             dout_n, valid_n, start_n, done_n;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic             par, par_n;
`endif

    assign accept = load_valid && load_ready && !rst;

    serial_pattern_tx_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (hold_wr),
        .wr_data    (load_data),
        .rd_en      (hold_rd),
        .rd_data    (hold_data),
        .load_ready (load_ready)
    );

    // Next-state, shifter/counter update, hold traffic and next output values.
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        cnt_n    = cnt;
        hold_rd  = 1'b0;
        direct   = 1'b0;
        last_bit = 1'b0;
        do_load  = 1'b0;
        new_word = load_data;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        par_n    = par;
`endif

        case (state)
            IDLE: begin
                if (accept) begin
                    direct  = 1'b1;
                    do_load = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    shreg_n = {shreg[WIDTH-2:0], 1'b0};
                    cnt_n   = cnt - CNT_ONE;
                end else begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    state_n = PARITY;
`else
                    last_bit = 1'b1;
`endif
                end
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            PARITY: begin
                last_bit = 1'b1;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase

        // Frame end: a held word wins; an empty hold lets a same-edge accept
        // go straight to the shifter so it is never stranded in the hold at IDLE.
        if (last_bit) begin
            if (!load_ready) begin
                hold_rd  = 1'b1;
                new_word = hold_data;
                do_load  = 1'b1;
            end else if (accept) begin
                direct  = 1'b1;
                do_load = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end

        if (do_load) begin
            shreg_n = new_word;
            cnt_n   = CNT_TOP;
            state_n = SHIFT;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par_n   = ^new_word;
`endif
        end

        hold_wr = accept && !direct;

        valid_n = (state_n != IDLE);
        start_n = (state_n == SHIFT) && (cnt_n == CNT_TOP);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        done_n  = (state_n == PARITY);
        dout_n  = (state_n == SHIFT) ? shreg_n[WIDTH-1] :
                  (state_n == PARITY) ? par_n : 1'b0;
`else
        done_n  = (state_n == SHIFT) && (cnt_n == '0);
        dout_n  = (state_n == SHIFT) ? shreg_n[WIDTH-1] : 1'b0;
`endif
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            cnt         <= cnt_n;
            dout        <= dout_n;
            dout_valid  <= valid_n;
            frame_start <= start_n;
            frame_done  <= done_n;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par         <= par_n;
`endif
        end
    end

    assign busy = dout_valid || !load_ready;

endmodule
